// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the fetch stage and decoder
package cpu_pkg;
    localparam logic [1:0]  PCSRC_SEQ          = 2'b00;
    localparam logic [1:0]  PCSRC_JUMP         = 2'b01;
    localparam logic [1:0]  PCSRC_JR           = 2'b10;
    localparam logic [31:0] NOP_INSTR          = 32'h0;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_IRQ_VECTOR = 32'h8000_0180;
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: combinational next-PC select and bubble decision for the fetch stage
// IF_INTERRUPT_EN adds the irq redirect
module if_next_pc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pcPlus4,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] jumpTarget,
    input  logic [31:0] jrTarget,
`ifdef IF_INTERRUPT_EN
    input  logic        irqTake,
    input  logic [31:0] irqVector,
`endif
    output logic [31:0] next_pc,
    output logic        load_bubble
);
    // later assignments override earlier ones, so the last written has highest priority
    always_comb begin
        next_pc = pcsrc == PCSRC_JUMP ? jumpTarget : pcsrc == PCSRC_JR ? jrTarget : pcPlus4;
        load_bubble = pcsrc == PCSRC_JUMP || pcsrc == PCSRC_JR;
`ifdef IF_INTERRUPT_EN
        if (irqTake) begin
            next_pc = irqVector;
            load_bubble = 1'b1;
        end
`endif
        if (stall) begin
            next_pc = pc;
            load_bubble = 1'b0;
        end
        if (branchTaken) begin
            next_pc = branchTarget;
            load_bubble = 1'b1;
        end
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, next-PC selection and IF/ID pipeline register
// IF_INTERRUPT_EN adds irq/id_irq ports and the IRQ_VECTOR parameter
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef IF_INTERRUPT_EN
    , parameter logic [31:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR
`endif
)(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  id_pcsrc,
    input  logic [31:0] id_rs_data,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
`ifdef IF_INTERRUPT_EN
    input  logic        irq,
    output logic        id_irq,
`endif
    output logic        kill_id_ex
);
    logic [31:0] pcPlus4, nextPc, jumpTarget, jrTarget;
    logic [1:0]  pcsrc;
    logic        loadBubble, advance, keepPc4;
    assign imem_addr  = pc;
    assign kill_id_ex = ex_branch_taken;
    assign pcPlus4    = pc + 32'd4;
    assign pcsrc      = id_valid ? id_pcsrc : PCSRC_SEQ;
    assign advance    = ex_branch_taken || !stall;
    assign jumpTarget = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
    assign jrTarget   = id_rs_data & ~32'h3;
`ifdef IF_INTERRUPT_EN
    logic irqTake;
    assign irqTake = irq && !stall && !ex_branch_taken;
    // an irq bubble still records the preempted PC+4 so EPC can be recovered
    assign keepPc4 = !loadBubble || irqTake;
`else
    assign keepPc4 = !loadBubble;
`endif
    if_next_pc u_next (
        .pc(pc),
        .pcPlus4(pcPlus4),
        .stall(stall),
        .branchTaken(ex_branch_taken),
        .branchTarget(ex_branch_target),
        .pcsrc(pcsrc),
        .jumpTarget(jumpTarget),
        .jrTarget(jrTarget),
`ifdef IF_INTERRUPT_EN
        .irqTake(irqTake),
        .irqVector(IRQ_VECTOR),
`endif
        .next_pc(nextPc),
        .load_bubble(loadBubble)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            id_instr    <= NOP_INSTR;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
`ifdef IF_INTERRUPT_EN
            id_irq      <= 1'b0;
`endif
        end else if (advance) begin
            pc          <= nextPc;
            id_instr    <= loadBubble ? NOP_INSTR : imem_rdata;
            id_pc_plus4 <= keepPc4 ? pcPlus4 : '0;
            id_valid    <= !loadBubble;
`ifdef IF_INTERRUPT_EN
            id_irq      <= irqTake;
`endif
        end
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Pipeline instruction-fetch stage: owns the PC register, selects the next PC and drives the IF/ID pipeline register. It acts on the control decoder's PCSrc output (jump/jr redirects resolved in ID) and on branch resolution from EX. It is the producer end of the instruction stream the decoder consumes.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset
IRQ_VECTOR, 32'h8000_0180, interrupt entry PC (used only with IF_INTERRUPT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
imem_addr  out  32  instruction memory address (= pc; combinational read)
imem_rdata  in  32  instruction word at imem_addr, same cycle
stall  in  1  hazard unit: hold PC and IF/ID
id_pcsrc  in  2  decoder PCSrc for the instruction in ID: 00 seq, 01 j/jal, 10 jr/jalr
id_rs_data  in  32  forwarded rs value, the jr/jalr target
ex_branch_taken  in  1  branch in EX resolved taken
ex_branch_target  in  32  branch target from EX
pc  out  32  current fetch PC
id_instr  out  32  IF/ID instruction
id_pc_plus4  out  32  IF/ID PC+4
id_valid  out  1  IF/ID holds a real instruction
kill_id_ex  out  1  combinational = ex_branch_taken; hazard unit clears ID/EX
irq  in  1  level interrupt request (IF_INTERRUPT_EN only)
id_irq  out  1  IF/ID entry is an interrupt bubble; EPC = id_pc_plus4 - 4 (IF_INTERRUPT_EN only)

Behaviour:
- Reset: pc=RESET_PC, id_instr=32'h0 (nop), id_pc_plus4=0, id_valid=0, id_irq=0. Reset is synchronous and overrides every input, including stall.
- No delay slots; 1-cycle fetch. pc_plus4 = pc + 32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Jump target = {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
- jr target = {id_rs_data[31:2], 2'b00}; the low bits are forced to zero and no fault is raised.
- Next-state priority, highest first:
  1. ex_branch_taken: pc<=ex_branch_target, IF/ID<=bubble. Ignores stall.
  2. stall: pc and IF/ID hold; a pending id_pcsrc is not acted on this cycle.
  3. id_pcsrc=01: pc<=jump target, IF/ID<=bubble.
  4. id_pcsrc=10: pc<=jr target, IF/ID<=bubble.
  5. Otherwise: pc<=pc_plus4, id_instr<=imem_rdata, id_pc_plus4<=pc_plus4, id_valid<=1.
- id_pcsrc=11 is illegal and is treated as 00.
- id_pcsrc is ignored while id_valid=0.
- Bubble: id_instr=0, id_valid=0, id_pc_plus4=0, id_irq=0.
- Branch plus ID jump in the same cycle: the branch wins and the jump, being younger, is discarded.
- Sub-module if_next_pc is combinational; all state stays in if_stage.

Optional Feature:
IF_INTERRUPT_EN
- Defined:
  - The irq, id_irq ports and the IRQ_VECTOR parameter exist.
  - irq sits between priority 2 and 3 and is taken only when not stalled and no branch is taken.
  - On take: pc<=IRQ_VECTOR, id_instr=0, id_valid=0, id_irq=1, id_pc_plus4=pc+4, where pc is the instruction being preempted.
  - irq is taken again on every eligible cycle while high; masking is the requester's job.
- Undefined: the ports are absent and id_irq is never generated.

Decomposition:
- Package cpu_pkg:
  - PCSRC_SEQ=2'b00, PCSRC_JUMP=2'b01, PCSRC_JR=2'b10
  - NOP_INSTR=32'h0
  - default RESET_PC and IRQ_VECTOR
- Sub-module if_next_pc: pure combinational next-PC and bubble-select. Inputs are the priority conditions, outputs are next_pc and load_bubble.

Test Plan:
- Reset, then 3 cycles with imem_rdata=A,B,C -> pc: 0x00400000, 04, 08, 0C; id_instr A,B,C; id_valid=1 from cycle 1.
- stall for 2 cycles at pc=0x00400008 -> pc and id_instr frozen; sequence resumes with no skipped or duplicated instruction.
- id_instr=32'h0810_0010 (j), id_pc_plus4=0x00400008, pcsrc=01 -> next pc=0x00400040, one bubble (id_valid=0).
- pcsrc=10, id_rs_data=0x00400123 -> pc=0x00400120, bubble.
- ex_branch_taken=1, target=0x00400200, with stall=1 and pcsrc=01 in the same cycle -> pc=0x00400200, bubble, kill_id_ex=1.
- IF_INTERRUPT_EN: irq=1 at pc=0x00400010, no stall -> pc=0x80000180, id_irq=1, id_pc_plus4=0x00400014. With stall=1 the irq is deferred.
